occ_ctrl: RTL and testbench

OCC_CTRL -- requirements
Module: occ_ctrl

---
 rtl/occ_ctrl_if.sv | 20 ++
 rtl/occ_ctrl.sv | 116 +++++++++++
 tb/tb_occ_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/occ_ctrl_if.sv
// Request/grant handshake and pointer-advance strobes between occ_ctrl (slave)
// and its producer/consumer side (master).
interface occ_ctrl_if;
  logic push_req;
  logic pop_req;
  logic push_gnt;
  logic pop_gnt;
  logic wr_ptr_inc;
  logic rd_ptr_inc;

  modport master (
    output push_req, pop_req,
    input  push_gnt, pop_gnt, wr_ptr_inc, rd_ptr_inc
  );

  modport slave (
    input  push_req, pop_req,
    output push_gnt, pop_gnt, wr_ptr_inc, rd_ptr_inc
  );
endinterface

// File: rtl/occ_ctrl.sv
// Occupancy controller for a DEPTH-slot buffer: grants push/pop, strobes external
// pointer counters, drains on flush. Define OCC_CTRL_ALMOST_EN for almost_full/almost_empty.
module occ_ctrl #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 5,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             flush_i,
  input  logic             err_clr_i,
  occ_ctrl_if.slave        bus,
  output logic [WIDTH-1:0] occupancy_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             busy_o,
  output logic             ovf_err_o,
  output logic             udf_err_o
`ifdef OCC_CTRL_ALMOST_EN
  ,
  output logic             almost_full_o,
  output logic             almost_empty_o
`endif
);

  if ((2 ** WIDTH) <= DEPTH || AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_params
    $error("occ_ctrl: WIDTH too narrow for DEPTH or threshold above DEPTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic full, empty, run, push_gnt, pop_gnt, drain;

  assign full  = (occ_q == WIDTH'(DEPTH));
  assign empty = (occ_q == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable_i) state_d = ST_RUN;
      ST_RUN: begin
        if (flush_i)        state_d = ST_FLUSH;
        else if (!enable_i) state_d = ST_IDLE;
      end
      ST_FLUSH: if (empty) state_d = enable_i ? ST_RUN : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Grants and strobes are held low while reset is asserted so an aborted
  // flush or transfer issues nothing in the reset cycle itself.
  always_comb begin
    run      = (state_q == ST_RUN);
    push_gnt = rst_n & run & bus.push_req & ~full;
    pop_gnt  = rst_n & run & bus.pop_req & ~empty;
    drain    = rst_n & (state_q == ST_FLUSH) & ~empty;
  end

  always_comb begin
    occ_d = occ_q;
    if (push_gnt && !pop_gnt)
      occ_d = occ_q + WIDTH'(1);
    else if ((pop_gnt && !push_gnt) || drain)
      occ_d = occ_q - WIDTH'(1);
    // A new error condition outranks a simultaneous clear.
    ovf_d = (run & bus.push_req & full)  | (ovf_q & ~err_clr_i);
    udf_d = (run & bus.pop_req  & empty) | (udf_q & ~err_clr_i);
  end

  assign bus.push_gnt   = push_gnt;
  assign bus.pop_gnt    = pop_gnt;
  assign bus.wr_ptr_inc = push_gnt;
  assign bus.rd_ptr_inc = pop_gnt | drain;

  assign occupancy_o = occ_q;
  assign full_o      = full;
  assign empty_o     = empty;
  assign busy_o      = (state_q == ST_FLUSH);
  assign ovf_err_o   = ovf_q;
  assign udf_err_o   = udf_q;

`ifdef OCC_CTRL_ALMOST_EN
  assign almost_full_o  = (occ_q >= WIDTH'(AF_LEVEL));
  assign almost_empty_o = (occ_q <= WIDTH'(AE_LEVEL));
`endif

endmodule

// File: tb/tb_occ_ctrl.sv
// Self-checking bench for occ_ctrl: directed scenarios plus randomized traffic
// compared against an arithmetic model of occupancy, mode and error flags.
module tb_occ_ctrl;
  localparam int DEPTH    = 16;
  localparam int WIDTH    = 5;
  localparam int AF_LEVEL = 14;
  localparam int AE_LEVEL = 2;
  localparam int M_IDLE   = 0;
  localparam int M_RUN    = 1;
  localparam int M_FLUSH  = 2;

  logic             clk = 1'b0;
  logic             rst_n, enable, flush, err_clr;
  logic [WIDTH-1:0] occupancy;
  logic             full, empty, busy, ovf_err, udf_err;
`ifdef OCC_CTRL_ALMOST_EN
  logic             almost_full, almost_empty;
`endif

  occ_ctrl_if bus ();

  occ_ctrl #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable_i(enable),
    .flush_i(flush),
    .err_clr_i(err_clr),
    .bus(bus),
    .occupancy_o(occupancy),
    .full_o(full),
    .empty_o(empty),
    .busy_o(busy),
    .ovf_err_o(ovf_err),
    .udf_err_o(udf_err)
`ifdef OCC_CTRL_ALMOST_EN
    ,
    .almost_full_o(almost_full),
    .almost_empty_o(almost_empty)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode, stored count and sticky flags.
  int m_mode = M_IDLE;
  int m_occ  = 0;
  bit m_ovf  = 1'b0;
  bit m_udf  = 1'b0;

  // {push_gnt, pop_gnt, wr_inc, rd_inc, full, empty, busy, ovf, udf, occupancy[4:0], af, ae}
  logic [15:0] act_vec, exp_vec;

  always_comb begin
    act_vec = {bus.push_gnt, bus.pop_gnt, bus.wr_ptr_inc, bus.rd_ptr_inc,
               full, empty, busy, ovf_err, udf_err, occupancy, 2'b00};
`ifdef OCC_CTRL_ALMOST_EN
    act_vec[1:0] = {almost_full, almost_empty};
`endif
  end

  function automatic logic [15:0] model_vec();
    bit pg, og, drain, af, ae;
    pg    = rst_n && m_mode == M_RUN && bus.push_req && m_occ < DEPTH;
    og    = rst_n && m_mode == M_RUN && bus.pop_req && m_occ > 0;
    drain = rst_n && m_mode == M_FLUSH && m_occ > 0;
    af    = 1'b0;
    ae    = 1'b0;
`ifdef OCC_CTRL_ALMOST_EN
    af = (m_occ >= AF_LEVEL);
    ae = (m_occ <= AE_LEVEL);
`endif
    return {pg, og, pg, og || drain, m_occ == DEPTH, m_occ == 0, m_mode == M_FLUSH,
            m_ovf, m_udf, WIDTH'(m_occ), af, ae};
  endfunction

  function automatic void model_update();
    bit run, pg, og, drain;
    int nxt;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_occ  = 0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      return;
    end
    run   = (m_mode == M_RUN);
    pg    = run && bus.push_req && m_occ < DEPTH;
    og    = run && bus.pop_req && m_occ > 0;
    drain = (m_mode == M_FLUSH) && m_occ > 0;
    m_ovf = (run && bus.push_req && m_occ == DEPTH) || (m_ovf && !err_clr);
    m_udf = (run && bus.pop_req && m_occ == 0) || (m_udf && !err_clr);
    nxt = m_mode;
    if (m_mode == M_IDLE && enable)                    nxt = M_RUN;
    else if (m_mode == M_RUN && flush)                 nxt = M_FLUSH;
    else if (m_mode == M_RUN && !enable)               nxt = M_IDLE;
    else if (m_mode == M_FLUSH && m_occ == 0)          nxt = enable ? M_RUN : M_IDLE;
    m_occ  = m_occ + int'(pg) - int'(og) - int'(drain);
    m_mode = nxt;
  endfunction

  // Inputs change just after the falling edge; outputs are observed 1 ns later.
  task automatic set_in(input bit en, input bit fl, input bit clr, input bit pu, input bit po);
    enable       = en;
    flush        = fl;
    err_clr      = clr;
    bus.push_req = pu;
    bus.pop_req  = po;
    #1;
    exp_vec = model_vec();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] rst_exp;
    rst_exp     = '0;
    rst_exp[10] = 1'b1;
`ifdef OCC_CTRL_ALMOST_EN
    rst_exp[0]  = 1'b1;
`endif
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      advance();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (act_vec !== rst_exp) begin
      n_fail++;
      $display("FAIL reset_state got %b want %b", act_vec, rst_exp);
    end
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_fill_overflow();
    int g = 0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL fill[%0d] got %b want %b", i, act_vec, exp_vec);
      end
      g += int'(bus.push_gnt);
      advance();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (g != DEPTH) begin
      n_fail++;
      $display("FAIL fill_grants got %0d want %0d", g, DEPTH);
    end
    n_checks++;
    if (occupancy !== 5'd16 || full !== 1'b1 || bus.push_gnt !== 1'b0) begin
      n_fail++;
      $display("FAIL full_refuse got occ=%0d full=%b gnt=%b want occ=16 full=1 gnt=0",
               occupancy, full, bus.push_gnt);
    end
    advance();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set got %b want 1", ovf_err);
    end
    advance();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (ovf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear got %b want 0", ovf_err);
    end
    advance();
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_beats_clr got %b want 1", ovf_err);
    end
    n_checks++;
    if (bus.push_gnt !== 1'b0 || bus.pop_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL full_push_pop got push=%b pop=%b want push=0 pop=1",
               bus.push_gnt, bus.pop_gnt);
    end
    advance();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (occupancy !== 5'd15) begin
      n_fail++;
      $display("FAIL full_push_pop_occ got %0d want 15", occupancy);
    end
    advance();
  endtask

  task automatic test_simultaneous();
    int wr = 0;
    int rd = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      wr += int'(bus.wr_ptr_inc);
      rd += int'(bus.rd_ptr_inc);
      advance();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (wr != 3 || rd != 3 || occupancy !== 5'd5) begin
      n_fail++;
      $display("FAIL push_pop_same got wr=%0d rd=%0d occ=%0d want wr=3 rd=3 occ=5",
               wr, rd, occupancy);
    end
  endtask

  task automatic test_flush();
    int busy_cnt = 0;
    int rd_cnt   = 0;
    int bad_gnt  = 0;
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      advance();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      if (!busy) break;
      busy_cnt++;
      rd_cnt  += int'(bus.rd_ptr_inc);
      bad_gnt += int'(bus.push_gnt) + int'(bus.pop_gnt);
      advance();
    end
    n_checks++;
    if (busy_cnt != 8 || rd_cnt != 7 || bad_gnt != 0) begin
      n_fail++;
      $display("FAIL flush7 got busy=%0d rd=%0d gnts=%0d want busy=8 rd=7 gnts=0",
               busy_cnt, rd_cnt, bad_gnt);
    end
    n_checks++;
    if (occupancy !== 5'd0 || bus.push_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_exit got occ=%0d push_gnt=%b want occ=0 push_gnt=1",
               occupancy, bus.push_gnt);
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    busy_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      if (!busy) break;
      busy_cnt++;
      advance();
    end
    n_checks++;
    if (busy_cnt != 1) begin
      n_fail++;
      $display("FAIL flush_empty got busy=%0d want 1", busy_cnt);
    end
  endtask

  task automatic test_underflow();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (bus.pop_gnt !== 1'b0 || occupancy !== 5'd0) begin
      n_fail++;
      $display("FAIL pop_empty got gnt=%b occ=%0d want gnt=0 occ=0", bus.pop_gnt, occupancy);
    end
    advance();
    set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (udf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL udf_set got %b want 1", udf_err);
    end
    advance();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (udf_err !== 1'b0) begin
      n_fail++;
      $display("FAIL udf_clear got %b want 0", udf_err);
    end
  endtask

  task automatic test_disable_and_reset();
    int gnts = 0;
    int strobes = 0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      advance();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      gnts += int'(bus.push_gnt) + int'(bus.pop_gnt) + int'(busy);
      advance();
    end
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (gnts != 0 || occupancy !== 5'd4) begin
      n_fail++;
      $display("FAIL idle_hold got gnts_busy=%0d occ=%0d want 0 and 4", gnts, occupancy);
    end
    advance();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      advance();
    end
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      advance();
    end
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus.rd_ptr_inc !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort_strobe got %b want 0", bus.rd_ptr_inc);
    end
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      strobes += int'(bus.rd_ptr_inc) + int'(bus.wr_ptr_inc) + int'(busy);
      advance();
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (strobes != 0 || occupancy !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_flush got strobes_busy=%0d occ=%0d want 0 and 0",
               strobes, occupancy);
    end
  endtask

  task automatic test_random();
    int pu_pct, po_pct;
    for (int i = 0; i < 900; i++) begin
      case ((i / 60) % 3)
        0:       begin pu_pct = 85; po_pct = 25; end
        1:       begin pu_pct = 25; po_pct = 85; end
        default: begin pu_pct = 50; po_pct = 50; end
      endcase
      rst_n = ($urandom_range(0, 299) != 0);
      set_in($urandom_range(0, 9) != 0, $urandom_range(0, 44) == 0,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 99) < pu_pct, $urandom_range(0, 99) < po_pct);
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random[%0d] got %b want %b", i, act_vec, exp_vec);
      end
      advance();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    test_reset();
    test_fill_overflow();
    test_simultaneous();
    test_flush();
    test_underflow();
    test_disable_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
